layer_compositor: RTL and testbench

Parametrised pixel compositor sitting between the VGA timing generator and the VGA DAC pins. It merges `LAYERS` sprite colour streams by fixed priority over a selectable background. It registers RGB, sync and blank through a matched 2-stage pipeline. It also reports per-frame layer-overlap (collision) flags and a frame counter to game logic.

---
 rtl/layer_compositor.sv | 171 +++++++++++++++++
 tb/tb_layer_compositor.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_compositor.sv
// ============================================================================
// Module      : layer_compositor
// Description : Priority sprite-layer merge over a selectable background with
//               a matched 2-stage VGA output pipeline and per-frame collisions.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module layer_compositor #(
    parameter int LAYERS      = 4,
    parameter int COLOR_W     = 8,
    parameter int COL_W       = 12,
    parameter int ROW_W       = 11,
    parameter int CHECK_SHIFT = 7,
    parameter int FRAME_W     = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [COL_W-1:0]                display_col,
    input  logic [ROW_W-1:0]                display_row,
    input  logic                            visible,
    input  logic                            hsync,
    input  logic                            vsync,
    input  logic [LAYERS*(3*COLOR_W+1)-1:0] layer_data,
    input  logic [1:0]                      bg_mode,
    input  logic [3*COLOR_W-1:0]            bg_color,
    output logic [COLOR_W-1:0]              VGA_R,
    output logic [COLOR_W-1:0]              VGA_G,
    output logic [COLOR_W-1:0]              VGA_B,
    output logic                            VGA_HS,
    output logic                            VGA_VS,
    output logic                            VGA_BLANK_N,
    output logic                            frame_tick,
    output logic [FRAME_W-1:0]              frame_count,
    output logic [LAYERS-1:0]               collision
);

    localparam int c_LW = 3*COLOR_W + 1;
    localparam int c_PW = 3*COLOR_W;

    logic [LAYERS-1:0]        w_valid;
    logic [c_PW-1:0]          w_color [LAYERS];
    logic                     w_hit;
    logic [c_PW-1:0]          w_win;
    logic                     w_seen;
    logic                     w_multi;
    logic                     w_chk_bit;
    logic [COLOR_W-1:0]       w_chk_ch;
    logic [COL_W+COLOR_W-1:0] w_grad_ext;
    logic [COLOR_W-1:0]       w_grad_ch;
    logic [c_PW-1:0]          w_bg;
    logic [c_PW-1:0]          w_pix;
    logic                     w_frame_edge;
    logic                     w_unused_bits;

    logic [1:0]               r_bg_mode;
    logic [c_PW-1:0]          r_bg_color;
    logic [c_PW-1:0]          r_s1_rgb;
    logic                     r_s1_vis;
    logic                     r_s1_hs;
    logic                     r_s1_vs;
    logic [LAYERS-1:0]        r_acc;

    generate
        for (genvar i = 0; i < LAYERS; i++) begin : g_layer
            assign w_valid[i] = layer_data[i*c_LW];
            assign w_color[i] = layer_data[i*c_LW+1 +: c_PW];
        end
    endgenerate

    // Scan from the highest index down so the lowest valid index is left last.
    always_comb begin
        w_hit = 1'b0;
        w_win = '0;
        for (int i = LAYERS-1; i >= 0; i--) begin
            if (w_valid[i]) begin
                w_hit = 1'b1;
                w_win = w_color[i];
            end
        end
    end

    always_comb begin
        w_seen  = 1'b0;
        w_multi = 1'b0;
        for (int i = 0; i < LAYERS; i++) begin
            if (w_valid[i]) begin
                if (w_seen) w_multi = 1'b1;
                w_seen = 1'b1;
            end
        end
    end

    assign w_chk_bit  = display_row[CHECK_SHIFT] ^ display_col[CHECK_SHIFT];
    assign w_chk_ch   = {3'b111, {(COLOR_W-3){w_chk_bit}}};
    assign w_grad_ext = {{COLOR_W{1'b0}}, display_col} >> 3;
    assign w_grad_ch  = w_grad_ext[COLOR_W-1:0];

    // Background selection only ever looks at the per-frame shadow registers.
    always_comb begin
        w_bg = '0;
        case (r_bg_mode)
            2'd0:    w_bg = {3{w_chk_ch}};
            2'd1:    w_bg = r_bg_color;
            2'd2:    w_bg = {3{w_grad_ch}};
            default: w_bg = '0;
        endcase
    end

    assign w_pix         = w_hit ? w_win : w_bg;
    assign w_frame_edge  = r_s1_vs & ~vsync;
    assign w_unused_bits = ^{display_row, display_col, w_grad_ext};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_s1_rgb <= '0;
            r_s1_vis <= 1'b0;
            r_s1_hs  <= 1'b1;
            r_s1_vs  <= 1'b1;
        end else begin
            r_s1_rgb <= w_pix;
            r_s1_vis <= visible;
            r_s1_hs  <= hsync;
            r_s1_vs  <= vsync;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            VGA_R       <= '0;
            VGA_G       <= '0;
            VGA_B       <= '0;
            VGA_HS      <= 1'b1;
            VGA_VS      <= 1'b1;
            VGA_BLANK_N <= 1'b0;
        end else begin
            VGA_R       <= r_s1_vis ? r_s1_rgb[3*COLOR_W-1:2*COLOR_W] : '0;
            VGA_G       <= r_s1_vis ? r_s1_rgb[2*COLOR_W-1:COLOR_W]   : '0;
            VGA_B       <= r_s1_vis ? r_s1_rgb[COLOR_W-1:0]           : '0;
            VGA_HS      <= r_s1_hs;
            VGA_VS      <= r_s1_vs;
            VGA_BLANK_N <= r_s1_vis;
        end
    end

    // Clear on the frame edge takes precedence over a same-cycle overlap.
    always_ff @(posedge clock) begin
        if (reset) begin
            frame_tick  <= 1'b0;
            frame_count <= '0;
            collision   <= '0;
            r_acc       <= '0;
            r_bg_mode   <= 2'd0;
            r_bg_color  <= '0;
        end else begin
            frame_tick <= w_frame_edge;
            if (w_frame_edge) begin
                frame_count <= frame_count + FRAME_W'(1);
                collision   <= r_acc;
                r_acc       <= '0;
                r_bg_mode   <= bg_mode;
                r_bg_color  <= bg_color;
            end else if (visible && w_multi) begin
                r_acc <= r_acc | w_valid;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_layer_compositor.sv
// Randomized bench for layer_compositor: a frame-level reference model feeds
// expected outputs into queues that an independent monitor compares.
`default_nettype none

module tb_layer_compositor;

    localparam int LAYERS = 4;
    localparam int LW     = 25;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [11:0]            display_col = '0;
    logic [10:0]            display_row = '0;
    logic                   visible = 1'b0;
    logic                   hsync = 1'b1;
    logic                   vsync = 1'b1;
    logic [LAYERS*LW-1:0]   layer_data = '0;
    logic [1:0]             bg_mode = '0;
    logic [23:0]            bg_color = '0;
    logic [7:0]             VGA_R, VGA_G, VGA_B;
    logic                   VGA_HS, VGA_VS, VGA_BLANK_N;
    logic                   frame_tick;
    logic [3:0]             frame_count;
    logic [LAYERS-1:0]      collision;

    layer_compositor #(
        .LAYERS(LAYERS), .COLOR_W(8), .COL_W(12), .ROW_W(11),
        .CHECK_SHIFT(7), .FRAME_W(4)
    ) dut (
        .clock(clock), .reset(reset),
        .display_col(display_col), .display_row(display_row),
        .visible(visible), .hsync(hsync), .vsync(vsync),
        .layer_data(layer_data), .bg_mode(bg_mode), .bg_color(bg_color),
        .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
        .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_BLANK_N(VGA_BLANK_N),
        .frame_tick(frame_tick), .frame_count(frame_count), .collision(collision)
    );

    always #5 clock = ~clock;

    typedef struct { int due; logic [23:0] rgb; logic hs; logic vs; logic bn; } vid_t;
    typedef struct { int due; logic tick; logic [3:0] cnt; logic [3:0] coll; } st_t;

    vid_t vq[$];
    st_t  sq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Reference model state: what the frame-level rules say is current.
    logic        m_vs_prev = 1'b1;
    logic [3:0]  m_acc = '0, m_coll = '0, m_cnt = '0;
    logic [1:0]  m_mode = '0;
    logic [23:0] m_color = '0;
    vid_t        pend;
    bit          have_pend = 1'b0;
    bit          pend_rst = 1'b0;

    function automatic logic [23:0] model_rgb(input logic [LAYERS*LW-1:0] ld,
                                              input logic [11:0] c, input logic [10:0] r,
                                              input logic [1:0] m, input logic [23:0] bc);
        logic [23:0] res;
        logic [7:0]  ch;
        logic [11:0] g;
        bit          found;
        found = 1'b0;
        res   = '0;
        for (int i = 0; i < LAYERS; i++) begin
            if (!found && ld[i*LW]) begin
                found = 1'b1;
                res   = ld[i*LW+1 +: 24];
            end
        end
        if (!found) begin
            case (m)
                2'd0: begin ch = (r[7] ^ c[7]) ? 8'hFF : 8'hE0; res = {ch, ch, ch}; end
                2'd1: res = bc;
                2'd2: begin g = c / 12'd8; ch = g[7:0]; res = {ch, ch, ch}; end
                default: res = '0;
            endcase
        end
        return res;
    endfunction

    // Record expectations for the inputs currently applied, then let one clock pass.
    task automatic step();
        int         k;
        int         nvalid;
        vid_t       v;
        st_t        s;
        logic [3:0] vmask;
        bit         edge_now;
        k = cyc + 1;
        if (have_pend) begin
            v = pend;
            if (reset || pend_rst) begin
                v.rgb = '0; v.hs = 1'b1; v.vs = 1'b1; v.bn = 1'b0;
            end
            v.due = k;
            vq.push_back(v);
        end
        pend.rgb  = visible ? model_rgb(layer_data, display_col, display_row, m_mode, m_color) : 24'h0;
        pend.hs   = hsync;
        pend.vs   = vsync;
        pend.bn   = visible;
        pend_rst  = reset;
        have_pend = 1'b1;

        nvalid = 0;
        for (int i = 0; i < LAYERS; i++) begin
            vmask[i] = layer_data[i*LW];
            nvalid += int'(vmask[i]);
        end
        if (reset) begin
            m_acc = '0; m_coll = '0; m_cnt = '0; m_mode = '0; m_color = '0;
            m_vs_prev = 1'b1;
            s.tick = 1'b0;
        end else begin
            edge_now = m_vs_prev && !vsync;
            if (edge_now) begin
                m_coll  = m_acc;
                m_acc   = '0;
                m_cnt   = m_cnt + 4'd1;
                m_mode  = bg_mode;
                m_color = bg_color;
            end else if (visible && nvalid >= 2) begin
                m_acc = m_acc | vmask;
            end
            m_vs_prev = vsync;
            s.tick    = edge_now;
        end
        s.cnt  = m_cnt;
        s.coll = m_coll;
        s.due  = k;
        sq.push_back(s);
        @(negedge clock);
    endtask

    task automatic clear_layers();
        layer_data = '0;
    endtask

    task automatic set_layer(input int i, input logic [23:0] c);
        layer_data[i*LW +: LW] = {c, 1'b1};
    endtask

    task automatic rand_layers(input int density);
        for (int i = 0; i < LAYERS; i++)
            layer_data[i*LW +: LW] = {24'($urandom), ($urandom_range(99) < density)};
    endtask

    task automatic vsync_edge();
        visible = 1'b0;
        clear_layers();
        vsync = 1'b0;
        step();
        step();
        vsync = 1'b1;
        step();
    endtask

    task automatic run_frame(input int density);
        for (int ln = 0; ln < 4; ln++) begin
            for (int px = 0; px < 12; px++) begin
                visible     = 1'b1;
                hsync       = 1'b1;
                display_col = 12'($urandom);
                display_row = 11'($urandom);
                rand_layers(density);
                if ($urandom_range(30) == 0) begin
                    bg_mode  = 2'($urandom);
                    bg_color = 24'($urandom);
                end
                step();
            end
            visible = 1'b0;
            hsync   = 1'b0;
            rand_layers(60);
            step();
            step();
            hsync = 1'b1;
        end
        vsync_edge();
    endtask

    initial begin : monitor
        vid_t mv;
        st_t  ms;
        forever begin
            @(posedge clock);
            cyc++;
            #1;
            if (vq.size() > 0 && vq[0].due == cyc) begin
                mv = vq.pop_front();
                checks++;
                if ({VGA_R, VGA_G, VGA_B} !== mv.rgb) begin
                    errors++;
                    $display("FAIL rgb cyc=%0d got=%h expected=%h", cyc, {VGA_R, VGA_G, VGA_B}, mv.rgb);
                end
                checks++;
                if ({VGA_HS, VGA_VS, VGA_BLANK_N} !== {mv.hs, mv.vs, mv.bn}) begin
                    errors++;
                    $display("FAIL sync_blank cyc=%0d got=%b expected=%b", cyc,
                             {VGA_HS, VGA_VS, VGA_BLANK_N}, {mv.hs, mv.vs, mv.bn});
                end
            end
            if (sq.size() > 0 && sq[0].due == cyc) begin
                ms = sq.pop_front();
                checks++;
                if (frame_tick !== ms.tick) begin
                    errors++;
                    $display("FAIL frame_tick cyc=%0d got=%b expected=%b", cyc, frame_tick, ms.tick);
                end
                checks++;
                if (frame_count !== ms.cnt) begin
                    errors++;
                    $display("FAIL frame_count cyc=%0d got=%0d expected=%0d", cyc, frame_count, ms.cnt);
                end
                checks++;
                if (collision !== ms.coll) begin
                    errors++;
                    $display("FAIL collision cyc=%0d got=%b expected=%b", cyc, collision, ms.coll);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
        $fatal(1, "timeout");
    end

    initial begin : driver
        @(negedge clock);
        reset = 1'b1;
        repeat (3) step();
        reset = 1'b0;

        // Checker squares around column 128, syncs passing through.
        visible = 1'b1; display_row = '0; display_col = '0; step();
        display_col = 12'd128; step();
        hsync = 1'b0; display_col = 12'd5; display_row = 11'd128; step();
        hsync = 1'b1;

        set_layer(1, 24'h102030); set_layer(3, 24'hAABBCC); step();
        visible = 1'b0; step();

        // Layers 0 and 2 overlap once, then a clean frame.
        clear_layers(); visible = 1'b1;
        set_layer(0, 24'h010203); set_layer(2, 24'h040506); step();
        clear_layers(); step();
        vsync_edge();
        visible = 1'b1;
        for (int i = 0; i < 5; i++) begin display_col = 12'($urandom); step(); end
        vsync_edge();

        // Mid-frame background change applies from the next frame only.
        visible = 1'b1; display_col = 12'd200; step();
        bg_mode = 2'd1; bg_color = 24'h123456;
        repeat (3) step();
        vsync_edge();
        visible = 1'b1; repeat (3) step();
        bg_mode = 2'd2; vsync_edge();
        visible = 1'b1; display_col = 12'h7F8; step();

        // Enough frames to wrap the 4-bit frame counter.
        for (int f = 0; f < 20; f++) run_frame((f % 3 == 0) ? 0 : 30);

        // Reset mid-frame after an overlap drops those hits.
        visible = 1'b1;
        set_layer(0, 24'h111111); set_layer(1, 24'h222222); step();
        reset = 1'b1; clear_layers(); repeat (2) step();
        reset = 1'b0;
        visible = 1'b1; set_layer(3, 24'h333333); repeat (3) step();
        vsync_edge();
        run_frame(50);

        visible = 1'b0; clear_layers(); repeat (3) step();

        checks++;
        if (vq.size() != 0 || sq.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d/%0d expected=0/0 pending items", vq.size(), sq.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
